// File: rtl/booth_r4_seq_mul_if.sv
// Operand/product handshake bundle for booth_r4_seq_mul.
// master = operand producer / product consumer, slave = the multiplier.
interface booth_r4_seq_mul_if;
   localparam int unsigned OP_W   = 32;
   localparam int unsigned PROD_W = 64;

   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   mulcand;
   logic [OP_W-1:0]   mulplier;
   logic              sign;
   logic              out_valid;
   logic              out_ready;
   logic [PROD_W-1:0] product;
   logic              busy;

   modport master (
      output in_valid, mulcand, mulplier, sign, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, mulcand, mulplier, sign, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/booth_r4_seq_mul.sv
// Sequential radix-4 Booth multiplier, 32x32 -> 64, one digit per clock.
// Optional early termination when all remaining digits are zero: define SEQ_MUL_EARLY_TERM_EN.
module booth_r4_seq_mul (
   input logic              clk,
   input logic              rst,
   booth_r4_seq_mul_if.slave bus
);
   localparam int unsigned OP_W   = 32;
   localparam int unsigned PROD_W = 64;
   localparam int unsigned MC_W   = OP_W + 1;   // extended multiplicand M
   localparam int unsigned PP_W   = OP_W + 2;   // partial product, holds +/-2M
   localparam int unsigned MR_W   = OP_W + 3;   // extended multiplier plus b[-1]
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned SH_W   = CNT_W + 1;
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(16);

`ifdef SEQ_MUL_EARLY_TERM_EN
   localparam bit EARLY_TERM = 1'b1;
`else
   localparam bit EARLY_TERM = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q;
   logic [MC_W-1:0]     mcand_q;
   logic [MR_W-1:0]     mr_q;
   logic [PROD_W-1:0]   acc_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                out_valid_q;
   logic                busy_q;

   logic [2:0]          digit;
   logic                neg;
   logic [PP_W-1:0]     m1;
   logic [PP_W-1:0]     m2;
   logic [PP_W-1:0]     mag;
   logic [PP_W-1:0]     pp;
   logic [SH_W-1:0]     shamt;
   logic [PROD_W-1:0]   term;
   logic [PROD_W-1:0]   corr;
   logic [PROD_W-1:0]   acc_nxt;
   logic                rest_zero;

   // Digit recode of the low three multiplier bits and the weighted accumulate.
   always_comb begin
      digit   = mr_q[2:0];
      neg     = 1'b0;
      mag     = '0;
      m1      = {mcand_q[MC_W-1], mcand_q};
      m2      = {mcand_q, 1'b0};
      case (digit)
         3'b001, 3'b010: mag = m1;
         3'b011:         mag = m2;
         3'b100: begin
            mag = m2;
            neg = 1'b1;
         end
         3'b101, 3'b110: begin
            mag = m1;
            neg = 1'b1;
         end
         default:        mag = '0;
      endcase
      pp      = neg ? ~mag : mag;
      shamt   = {cnt_q, 1'b0};
      term    = {{(PROD_W-PP_W){pp[PP_W-1]}}, pp} << shamt;
      corr    = {{(PROD_W-1){1'b0}}, neg} << shamt;
      acc_nxt = acc_q + term + corr;
      // Remaining digits are all 000/111 exactly when the unconsumed bits are uniform.
      rest_zero = (mr_q == '0) || (mr_q == '1);
   end

   // Control state, operand capture and accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mcand_q     <= '0;
         mr_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  mcand_q <= {bus.sign & bus.mulcand[OP_W-1], bus.mulcand};
                  mr_q    <= {{2{bus.sign & bus.mulplier[OP_W-1]}}, bus.mulplier, 1'b0};
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (EARLY_TERM && rest_zero) begin
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  acc_q <= acc_nxt;
                  mr_q  <= {{2{mr_q[MR_W-1]}}, mr_q[MR_W-1:2]};
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_DIGIT) begin
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   // in_ready must drop in the same cycle rst is raised, so it is gated directly.
   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.product   = acc_q;

endmodule
